// File: rtl/nb_ldpc_pkg.sv
// Shared constants and helpers for the non-binary LDPC datapath.
// Field size, LLR width defaults, null-coefficient encoding and mode codes.
package nb_ldpc_pkg;

    localparam int GF_M_DEF    = 2;
    localparam int LLR_BIT_DEF = 3;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    function automatic int gf_n(input int m);
        return (1 << m) - 1;
    endfunction

    // A null edge is coded as the all-ones exponent, which equals N.
    function automatic int null_coef(input int m);
        return gf_n(m);
    endfunction

endpackage

// File: rtl/llr_rotate.sv
// Combinational N-entry barrel rotator: entry k takes source entry (k - shift) mod N.
// Shift must be below N; it is reduced again here so larger codes stay defined.
module llr_rotate #(
    parameter int N       = 3,
    parameter int LLR_BIT = 3,
    parameter int SHIFT_W = 2
) (
    input  logic [N*LLR_BIT-1:0] llr,
    input  logic [SHIFT_W-1:0]   shift,
    output logic [N*LLR_BIT-1:0] rotated
);

    function automatic int src(input int k, input int s);
        return (k + N - (s % N)) % N;
    endfunction

    always_comb begin
        rotated = '0;
        for (int k = 0; k < N; k++) begin
            rotated[k*LLR_BIT +: LLR_BIT] = llr[src(k, int'(shift))*LLR_BIT +: LLR_BIT];
        end
    end

endmodule

// File: rtl/llr_permute_pipe.sv
// Two-stage GF(2^M) LLR permutation with valid/ready flow control.
// Stage 1 registers payload and shift; stage 2 rotates or forces the null vector.
module llr_permute_pipe
    import nb_ldpc_pkg::*;
#(
    parameter int GF_M     = GF_M_DEF,
    parameter int LLR_BIT  = LLR_BIT_DEF,
    parameter int TAG_W    = 4,
    parameter int NULL_LLR = 3,
    localparam int N       = gf_n(GF_M)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [N*LLR_BIT-1:0] INPUT_LLR,
    input  logic [GF_M-1:0]      INPUT_COEF,
    input  logic                 INPUT_MODE,
    input  logic [TAG_W-1:0]     INPUT_TAG,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [N*LLR_BIT-1:0] OUTPUT_LLR,
    output logic [TAG_W-1:0]     OUTPUT_TAG
);

    localparam int W = N * LLR_BIT;
    localparam logic [GF_M-1:0]    NULL_C = GF_M'(null_coef(GF_M));
    localparam logic [LLR_BIT-1:0] NULL_E = LLR_BIT'(NULL_LLR);

    logic             v1, v2, null1;
    logic             ready1, ready2;
    logic [W-1:0]     llr1, rot;
    logic [TAG_W-1:0] tag1;
    logic [GF_M-1:0]  s1, shift, n_minus_c;

    assign ready2   = !v2 || OUT_READY;
    assign ready1   = !v1 || ready2;
    assign IN_READY = ready1;
    assign OUT_VALID = v2;

    // Division by alpha^c is multiplication by alpha^(N-c); c=0 must stay 0.
    assign n_minus_c = GF_M'(N) - INPUT_COEF;
    assign shift = (INPUT_MODE == MODE_INV && INPUT_COEF != '0) ? n_minus_c : INPUT_COEF;

    llr_rotate #(
        .N       (N),
        .LLR_BIT (LLR_BIT),
        .SHIFT_W (GF_M)
    ) u_rot (
        .llr     (llr1),
        .shift   (s1),
        .rotated (rot)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            llr1       <= '0;
            tag1       <= '0;
            s1         <= '0;
            null1      <= 1'b0;
            OUTPUT_LLR <= '0;
            OUTPUT_TAG <= '0;
        end else begin
            if (ready1) begin
                v1 <= IN_VALID;
                if (IN_VALID) begin
                    llr1  <= INPUT_LLR;
                    tag1  <= INPUT_TAG;
                    s1    <= shift;
                    null1 <= (INPUT_COEF == NULL_C);
                end
            end
            if (ready2) begin
                v2 <= v1;
                if (v1) begin
                    OUTPUT_LLR <= null1 ? {N{NULL_E}} : rot;
                    OUTPUT_TAG <= tag1;
                end
            end
        end
    end

endmodule

// File: tb/tb_llr_permute_pipe.sv
// Bench for llr_permute_pipe: GF(4) vectors, backpressure and reset on one
// instance, GF(8) round trip and throughput on a second instance.
module tb_llr_permute_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       a_iv, a_ir, a_m, a_ov, a_or;
    logic [8:0] a_llr, a_ollr;
    logic [1:0] a_c;
    logic [3:0] a_tag, a_otag;

    logic        b_iv, b_ir, b_m, b_ov, b_or;
    logic [20:0] b_llr, b_ollr;
    logic [2:0]  b_coef;
    logic [3:0]  b_tag, b_otag;

    llr_permute_pipe #(.GF_M(2), .LLR_BIT(3), .TAG_W(4), .NULL_LLR(3)) dut_a (
        .CLK(clk), .RST(rst), .IN_VALID(a_iv), .IN_READY(a_ir),
        .INPUT_LLR(a_llr), .INPUT_COEF(a_c), .INPUT_MODE(a_m), .INPUT_TAG(a_tag),
        .OUT_VALID(a_ov), .OUT_READY(a_or), .OUTPUT_LLR(a_ollr), .OUTPUT_TAG(a_otag)
    );

    llr_permute_pipe #(.GF_M(3), .LLR_BIT(3), .TAG_W(4), .NULL_LLR(3)) dut_b (
        .CLK(clk), .RST(rst), .IN_VALID(b_iv), .IN_READY(b_ir),
        .INPUT_LLR(b_llr), .INPUT_COEF(b_coef), .INPUT_MODE(b_m), .INPUT_TAG(b_tag),
        .OUT_VALID(b_ov), .OUT_READY(b_or), .OUTPUT_LLR(b_ollr), .OUTPUT_TAG(b_otag)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0] llr;
        logic [1:0] c;
        logic       m;
        logic [3:0] tag;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[8];

    logic [20:0] b_in[7];
    logic [20:0] b_out[7];
    logic [20:0] orig[7];
    logic [2:0]  cs[7];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Symbol alpha^e times alpha^c lands on alpha^(e+c); division goes the other way.
    function automatic logic [20:0] ref_perm(input int n, input logic [20:0] x,
                                             input int c, input logic m);
        logic [20:0] r;
        int dst;
        r = '0;
        for (int e = 0; e < n; e++) begin
            if (c == n) begin
                r[e*3 +: 3] = 3'd3;
            end else begin
                dst = m ? (e - c + n) % n : (e + c) % n;
                r[dst*3 +: 3] = x[e*3 +: 3];
            end
        end
        return r;
    endfunction

    task automatic apply_a(input vec_t v, input string nm);
        @(negedge clk);
        a_or = 1'b1; a_iv = 1'b1;
        a_llr = v.llr; a_c = v.c; a_m = v.m; a_tag = v.tag;
        @(posedge clk);
        @(negedge clk);
        a_iv = 1'b0;
        chk({nm, " early"}, 32'(a_ov), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({nm, " valid"}, 32'(a_ov), 32'd1);
        chk({nm, " llr"}, 32'(a_ollr), 32'(v.exp));
        chk({nm, " tag"}, 32'(a_otag), 32'(v.tag));
    endtask

    task automatic stream_b(input logic m, input string nm);
        int sent = 0;
        int got = 0;
        int first = -1;
        int last = -1;
        for (int cyc = 0; cyc < 60 && got < 7; cyc++) begin
            @(negedge clk);
            b_or = 1'b1;
            if (sent < 7) begin
                b_iv = 1'b1; b_llr = b_in[sent]; b_coef = cs[sent];
                b_m = m; b_tag = 4'(sent);
            end else begin
                b_iv = 1'b0;
            end
            #1;
            if (b_ov) begin
                b_out[got] = b_ollr;
                chk({nm, " tag"}, 32'(b_otag), 32'(got));
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (b_iv && b_ir) sent++;
        end
        b_iv = 1'b0;
        chk({nm, " count"}, 32'(got), 32'd7);
        chk({nm, " rate"}, 32'(last - first), 32'd6);
    endtask

    initial begin
        logic [8:0]  bp_llr[8];
        logic [1:0]  bp_c[8];
        logic        bp_m[8];
        logic [12:0] q[$];
        logic [12:0] e;
        logic        stall;
        logic [8:0]  prev_llr;
        logic [3:0]  prev_tag;
        int sent, got;

        tbl[0] = '{9'h0D1, 2'd0, 1'b0, 4'h1, 9'h0D1};
        tbl[1] = '{9'h0D1, 2'd1, 1'b0, 4'h2, 9'h08B};
        tbl[2] = '{9'h0D1, 2'd1, 1'b1, 4'h3, 9'h05A};
        tbl[3] = '{9'h0D1, 2'd2, 1'b1, 4'h4, 9'h08B};
        tbl[4] = '{9'h0D1, 2'd3, 1'b0, 4'h5, 9'h0DB};
        tbl[5] = '{9'h0D1, 2'd3, 1'b1, 4'h6, 9'h0DB};
        tbl[6] = '{9'h0D1, 2'd0, 1'b1, 4'h7, 9'h0D1};
        tbl[7] = '{9'h0D1, 2'd2, 1'b0, 4'h8, 9'h05A};

        rst = 1'b1;
        a_iv = 0; a_or = 0; a_llr = 0; a_c = 0; a_m = 0; a_tag = 0;
        b_iv = 0; b_or = 0; b_llr = 0; b_coef = 0; b_m = 0; b_tag = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset out_valid", 32'(a_ov), 32'd0);
        chk("reset llr", 32'(a_ollr), 32'd0);
        chk("reset tag", 32'(a_otag), 32'd0);
        chk("reset in_ready", 32'(a_ir), 32'd1);
        chk("reset b out_valid", 32'(b_ov), 32'd0);

        for (int i = 0; i < 8; i++) apply_a(tbl[i], $sformatf("vec%0d", i));

        // Fill both stages against a stalled sink, then reset.
        @(negedge clk);
        a_or = 1'b0; a_iv = 1'b1; a_llr = 9'h0D1; a_c = 2'd1; a_m = 1'b0; a_tag = 4'hA;
        @(negedge clk);
        a_tag = 4'hB;
        @(negedge clk);
        #1;
        chk("full in_ready", 32'(a_ir), 32'd0);
        chk("full out_valid", 32'(a_ov), 32'd1);
        rst = 1'b1; a_iv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst out_valid", 32'(a_ov), 32'd0);
        chk("midrst llr", 32'(a_ollr), 32'd0);
        chk("midrst in_ready", 32'(a_ir), 32'd1);
        apply_a(tbl[1], "post reset");

        // Backpressure with ready pattern 1,0,0 repeating.
        for (int i = 0; i < 8; i++) begin
            bp_llr[i] = 9'($urandom);
            bp_c[i] = 2'($urandom_range(0, 3));
            bp_m[i] = 1'($urandom);
        end
        sent = 0; got = 0; stall = 1'b0; prev_llr = '0; prev_tag = '0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            @(negedge clk);
            a_or = (cyc % 3 == 0);
            if (sent < 8) begin
                a_iv = 1'b1; a_llr = bp_llr[sent]; a_c = bp_c[sent];
                a_m = bp_m[sent]; a_tag = 4'(sent);
            end else begin
                a_iv = 1'b0;
            end
            #1;
            if (stall) begin
                chk("bp stall valid", 32'(a_ov), 32'd1);
                chk("bp stall llr", 32'(a_ollr), 32'(prev_llr));
                chk("bp stall tag", 32'(a_otag), 32'(prev_tag));
            end
            chk("bp in_ready", 32'(a_ir), 32'((q.size() < 2) || a_or));
            if (a_ov && a_or) begin
                if (q.size() == 0) begin
                    chk("bp spurious", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("bp llr", 32'(a_ollr), 32'(e[12:4]));
                    chk("bp tag", 32'(a_otag), 32'(e[3:0]));
                end
                got++;
            end
            if (a_iv && a_ir) begin
                e[12:4] = 9'(ref_perm(3, 21'(bp_llr[sent]), int'(bp_c[sent]), bp_m[sent]));
                e[3:0] = 4'(sent);
                q.push_back(e);
                sent++;
            end
            stall = a_ov && !a_or;
            prev_llr = a_ollr;
            prev_tag = a_otag;
        end
        a_iv = 1'b0;
        chk("bp count", 32'(got), 32'd8);

        // GF(8) forward for every c, then inverse of the results.
        for (int i = 0; i < 7; i++) begin
            orig[i] = 21'($urandom);
            b_in[i] = orig[i];
            cs[i] = 3'(i);
        end
        stream_b(1'b0, "fwd");
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("fwd c%0d", i), 32'(b_out[i]), 32'(ref_perm(7, orig[i], i, 1'b0)));
            b_in[i] = b_out[i];
        end
        stream_b(1'b1, "inv");
        for (int i = 0; i < 7; i++)
            chk($sformatf("roundtrip c%0d", i), 32'(b_out[i]), 32'(orig[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/llr_permute_pipe.md
Name: llr_permute_pipe

Overview:
- Pipelined, parametrised GF(2^M) LLR permutation unit for the non-binary LDPC decoder.
- Applies the Tanner-graph edge coefficient h = alpha^c to a vector of N = 2^M-1 LLRs, one LLR per nonzero field symbol.
- Forward mode (variable-to-check) multiplies by h; inverse mode (check-to-variable) divides by h.
- Sits between the VN/CN processors and the message memories. Uses a valid/ready stream with full throughput and backpressure.

Parameters:
- GF_M, 2: field is GF(2^GF_M); N = 2^GF_M - 1 LLR entries.
- LLR_BIT, 3: signed LLR width per entry.
- TAG_W, 4: sideband tag width (edge index, etc.), carried unchanged.
- NULL_LLR, 3: value forced into every entry on a null edge (signed, LLR_BIT wide).

Ports:
- CLK, input, 1: clock.
- RST, input, 1: synchronous, active-high reset.
- IN_VALID, input, 1: input word valid.
- IN_READY, output, 1: unit can accept the input word.
- INPUT_LLR, input, N*LLR_BIT: entry e (bits e*LLR_BIT +: LLR_BIT) is the LLR of symbol alpha^e, e = 0..N-1.
- INPUT_COEF, input, GF_M: coefficient exponent c. The all-ones value (N) means a null/zero edge.
- INPUT_MODE, input, 1: 0 = forward (x h), 1 = inverse (/ h).
- INPUT_TAG, input, TAG_W: sideband.
- OUT_VALID, output, 1: output word valid.
- OUT_READY, input, 1: downstream accepts.
- OUTPUT_LLR, output, N*LLR_BIT: permuted LLR vector.
- OUTPUT_TAG, output, TAG_W: sideband aligned with OUTPUT_LLR.

Behaviour:
- Handshake and reset
  - A transfer occurs on a CLK edge where VALID and READY are both 1.
  - Payload must stay stable while VALID=1 and READY=0; the unit holds its outputs stable under stall.
  - Reset: stage valids = 0, OUT_VALID = 0, OUTPUT_LLR = 0, OUTPUT_TAG = 0, IN_READY = 1 on the first cycle after reset.
  - RST asserted mid-operation discards all in-flight words; no partial output appears.
- Stage 1 (register)
  - Captures INPUT_LLR and INPUT_TAG.
  - Computes shift s = c when MODE=0, and s = (N - c) mod N when MODE=1 (c=0 gives s=0).
  - Computes null = (c == N).
- Stage 2 (register)
  - Barrel rotate: OUTPUT entry k = stage-1 entry (k - s) mod N, for k = 0..N-1.
  - If null, every entry = NULL_LLR, regardless of mode or input.
  - The TAG is carried through unchanged.
- Latency and throughput
  - Latency is exactly 2 cycles from input transfer to OUT_VALID when not stalled.
  - Throughput is 1 word per cycle.
- Ready chain: stage2_ready = !v2 | OUT_READY; stage1_ready = !v1 | stage2_ready; IN_READY = stage1_ready.
  - This is a combinational ready path; no bubbles under continuous flow.
  - Simultaneous drain and fill of a stage in the same cycle is legal and must not lose or duplicate a word.
- Ordering: words emerge in input order. No internal reordering and no drop except on reset.
- Arithmetic
  - Modulo-N reduction is on GF_M+1 bits; no saturation is needed since entries are moved, not computed.
  - c = 0 in either mode gives the identity.
  - Inverse(c) composed with forward(c) is the identity for every c < N.

Decomposition:
- Shared package nb_ldpc_pkg holds:
  - the LLR_BIT / GF_M defaults;
  - the function gf_n(m) = 2^m - 1;
  - the constant encoding of the null coefficient (all ones);
  - the MODE_FWD = 0 and MODE_INV = 1 constants.
- One natural sub-module: llr_rotate, a purely combinational N-entry barrel rotator parametrised by N, LLR_BIT and the shift width.
  - Instantiated in stage 2 and reusable by the CN sorter.
- Pipeline registers and handshake logic live in llr_permute_pipe.

Test Plan:
- Identity and forward (GF_M=2, LLR_BIT=3, N=3; all vectors below use INPUT_LLR = 0x0D1, i.e. entries {e2,e1,e0} = {3,2,1}):
  - c=0, MODE=0 -> OUTPUT_LLR = 0x0D1, two cycles later.
  - c=1, MODE=0 -> entries {2,1,3} = 0x08B.
- Inverse: same input, c=1, MODE=1 -> {1,3,2} = 0x05A; c=2, MODE=1 -> 0x08B (equal to forward c=1).
- Null edge: c=3, any mode -> 0x0DB (all entries 3); TAG passes unchanged.
- Backpressure:
  - Stream 8 words with incrementing tags 0..7 and OUT_READY toggling 1,0,0,1,...
  - Required: all 8 outputs in order with correct payloads; OUTPUT_LLR stable during stalls; IN_READY drops only when both stages are full.
- Round trip (GF_M=3, N=7): random vectors, forward c then inverse c for all c = 0..6 -> output equals original; continuous flow gives 1 word/cycle.
- Reset mid-stream: assert RST with both stages full -> next cycle OUT_VALID = 0, OUTPUT_LLR = 0, IN_READY = 1; first post-reset word emerges after 2 cycles.
